hazard_stall_controller: RTL

- Pipeline sequencer for the 5-stage rv32i core. It drives the load enables and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Handles three hazard classes:
  - memory freezes from cache misses, where the whole pipe holds;
  - taken-branch/jump redirects from EX, which flush the wrong-path instructions;
  - load-use hazards, resolved by one bubble because WB-to-EX forwarding covers the rest.
- Keeps saturating performance counters and a sticky hang detector.

---
 rtl/hazard_stall_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_controller
//  Purpose  : Pipeline sequencer for the 5-stage rv32i core. Drives the
//             per-stage load enables and flushes for memory freezes,
//             EX-stage redirects and load-use bubbles. Also keeps saturating
//             performance counters and a sticky hang detector.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_controller #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_dest,
    input  logic             br_taken_ex,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             load_pc,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             hang_err
);

    // Freeze-run counter only needs to count up to TIMEOUT and then park there.
    localparam int                c_fc_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_fc_w-1:0] c_frz_max  = c_fc_w'(TIMEOUT);
    localparam logic [c_fc_w-1:0] c_frz_last = c_fc_w'(TIMEOUT - 1);
    localparam logic [c_fc_w-1:0] c_fc_one   = c_fc_w'(1);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

    // REDIRECT means "frozen, and a taken branch is still owed a flush".
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FREEZE   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_fc_w-1:0] r_frz_cnt;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_count;
    logic              r_hang_err;
    logic              r_redirect_q;

    logic w_freeze;
    logic w_pending;
    logic w_redirect;
    logic w_raw_hit;
    logic w_load_use;

    // Hazard classification in priority order: freeze > redirect > load-use.
    always_comb begin
        w_freeze   = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);
        w_pending  = (r_state == ST_REDIRECT);
        w_redirect = (br_taken_ex | w_pending) & ~w_freeze;
        w_raw_hit  = ex_valid & ex_is_load & (ex_dest != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_dest)) |
                      (id_uses_rs2 & (id_rs2 == ex_dest)));
        w_load_use = w_raw_hit & ~w_freeze & ~w_redirect;
    end

    // Next-state and pipeline control outputs; everything held low in reset.
    always_comb begin
        w_state_nxt = ST_RUN;
        load_pc     = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;

        if (w_freeze) begin
            w_state_nxt = (br_taken_ex | w_pending) ? ST_REDIRECT : ST_FREEZE;
        end

        if (!rst) begin
            w_state_nxt = ST_RUN;
        end else if (w_freeze) begin
            // Whole pipe holds; nothing moves, nothing is flushed.
        end else if (w_redirect) begin
            load_pc     = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX.
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_id_ex = 1'b1;
        end else begin
            load_pc     = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Consecutive-freeze counter and sticky hang flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frz_cnt  <= '0;
            r_hang_err <= 1'b0;
        end else if (w_freeze) begin
            if (r_frz_cnt != c_frz_max) begin
                r_frz_cnt <= r_frz_cnt + c_fc_one;
            end
            if (r_frz_cnt >= c_frz_last) begin
                r_hang_err <= 1'b1;
            end
        end else begin
            r_frz_cnt <= '0;
        end
    end

    // Saturating performance counters; a flush is counted on the first
    // cycle of each redirect so a long-held redirect counts only once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
            r_redirect_q   <= 1'b0;
        end else begin
            r_redirect_q <= w_redirect;
            if ((w_freeze | w_load_use) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
            end
            if (w_redirect && !r_redirect_q && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + c_cnt_one;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
    assign hang_err     = r_hang_err;

endmodule
`default_nettype wire
